// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states, ALU timing.
package alu_pkg;

  // Opcodes understood by the downstream 8-bit registered ALU.
  // Any code above ALU_NEQ makes the ALU pass operand A through.
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_MUL  = 4'h2;
  localparam logic [3:0] ALU_SHL  = 4'h3;
  localparam logic [3:0] ALU_SHR  = 4'h4;
  localparam logic [3:0] ALU_INCA = 4'h5;
  localparam logic [3:0] ALU_INCB = 4'h6;
  localparam logic [3:0] ALU_DECA = 4'h7;
  localparam logic [3:0] ALU_DECB = 4'h8;
  localparam logic [3:0] ALU_EQ   = 4'h9;
  localparam logic [3:0] ALU_GT   = 4'hA;
  localparam logic [3:0] ALU_LT   = 4'hB;
  localparam logic [3:0] ALU_NEQ  = 4'hC;

  // Registered ALU: the result appears one cycle after the operands are sampled.
  // The sequencer's single EXEC cycle is sized for this latency.
  localparam int ALU_LATENCY = 1;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_WB   = 2'b10
  } seq_state_t;

  // True for opcodes the ALU defines; everything else is a pass-A.
  function automatic logic op_is_defined(input logic [3:0] op);
    return (op <= ALU_NEQ);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, host-load, ALU and result signals of the ALU command sequencer.
interface alu_cmd_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4
);
  localparam int ADDR_W = $clog2(NREGS);

  // Command handshake
  logic              CMD_VALID;
  logic              CMD_READY;
  logic [3:0]        CMD_OP;
  logic [ADDR_W-1:0] CMD_SRC_A;
  logic [ADDR_W-1:0] CMD_SRC_B;
  logic [ADDR_W-1:0] CMD_DST;
  logic              CMD_WE;

  // Host register load
  logic              LOAD_EN;
  logic [ADDR_W-1:0] LOAD_ADDR;
  logic [DATA_W-1:0] LOAD_DATA;

  // ALU connection
  logic [DATA_W-1:0] ALU_IN_A;
  logic [DATA_W-1:0] ALU_IN_B;
  logic [3:0]        ALU_OP;
  logic [DATA_W-1:0] ALU_RESULT;

  // Result report
  logic              RESULT_VALID;
  logic [DATA_W-1:0] RESULT_DATA;
  logic [ADDR_W-1:0] RESULT_DST;

  // Sequencer side
  modport slave (
    input  CMD_VALID, CMD_OP, CMD_SRC_A, CMD_SRC_B, CMD_DST, CMD_WE,
    input  LOAD_EN, LOAD_ADDR, LOAD_DATA,
    input  ALU_RESULT,
    output CMD_READY,
    output ALU_IN_A, ALU_IN_B, ALU_OP,
    output RESULT_VALID, RESULT_DATA, RESULT_DST
  );

  // Host + ALU side
  modport master (
    output CMD_VALID, CMD_OP, CMD_SRC_A, CMD_SRC_B, CMD_DST, CMD_WE,
    output LOAD_EN, LOAD_ADDR, LOAD_DATA,
    output ALU_RESULT,
    input  CMD_READY,
    input  ALU_IN_A, ALU_IN_B, ALU_OP,
    input  RESULT_VALID, RESULT_DATA, RESULT_DST
  );

endinterface

// File: rtl/alu_regfile.sv
// Operand register file: NREGS x DATA_W, two asynchronous read ports and
// synchronous writes. Write port 0 is the ALU write-back, port 1 the host load;
// the parent masks port 1 on an address collision, and port 0 is applied last.
module alu_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_we0,
  input  logic [ADDR_W-1:0] i_waddr0,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_waddr1,
  input  logic [DATA_W-1:0] i_wdata1,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_mem [NREGS];

  // Clear on reset; otherwise apply host load then write-back (write-back last).
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_we1) r_mem[i_waddr1] <= i_wdata1;
      if (i_we0) r_mem[i_waddr0] <= i_wdata0;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Upstream control stage for the registered ALU: accepts a command, fetches
// both operands from the register file, presents them to the ALU for one
// cycle, then reports the result and optionally writes it back.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  alu_cmd_sequencer_if.slave bus
);

  localparam int ADDR_W = $clog2(NREGS);

  seq_state_t        r_state;
  logic [3:0]        r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [ADDR_W-1:0] r_dst;
  logic              r_we;
  logic [DATA_W-1:0] r_res_data;
  logic [ADDR_W-1:0] r_res_dst;

  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic              w_ready;
  logic              w_accept;
  logic              w_in_wb;
  logic              w_wb_we;
  logic              w_load_we;

  assign w_in_wb  = (r_state == S_WB);
  // Ready is a decode of the state, forced low while reset is held.
  assign w_ready  = (r_state == S_IDLE) && !RESET;
  assign w_accept = bus.CMD_VALID && w_ready;

  // Write-back happens at the edge that leaves WB. A host load to the same
  // index at that edge is dropped; a load to a different index still lands.
  assign w_wb_we   = w_in_wb && r_we;
  assign w_load_we = bus.LOAD_EN && !(w_wb_we && (bus.LOAD_ADDR == r_dst));

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .CLK       (CLK),
    .RESET     (RESET),
    .i_we0     (w_wb_we),
    .i_waddr0  (r_dst),
    .i_wdata0  (bus.ALU_RESULT),
    .i_we1     (w_load_we),
    .i_waddr1  (bus.LOAD_ADDR),
    .i_wdata1  (bus.LOAD_DATA),
    .i_raddr_a (bus.CMD_SRC_A),
    .i_raddr_b (bus.CMD_SRC_B),
    .o_rdata_a (w_rd_a),
    .o_rdata_b (w_rd_b)
  );

  // Command FSM: latch command and operands on accept, wait out the ALU
  // latency in EXEC, capture the result for hold-over as WB ends.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_dst      <= '0;
      r_we       <= 1'b0;
      r_res_data <= '0;
      r_res_dst  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= bus.CMD_OP;
            r_a     <= w_rd_a;
            r_b     <= w_rd_b;
            r_dst   <= bus.CMD_DST;
            r_we    <= bus.CMD_WE;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_state <= S_WB;
        end
        S_WB: begin
          r_res_data <= bus.ALU_RESULT;
          r_res_dst  <= r_dst;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.CMD_READY = w_ready;

  // Operands and opcode hold their last latched values outside EXEC.
  assign bus.ALU_IN_A = r_a;
  assign bus.ALU_IN_B = r_b;
  assign bus.ALU_OP   = r_op;

  // In WB the ALU output is passed straight through; otherwise the last
  // reported result is held.
  assign bus.RESULT_VALID = w_in_wb && !RESET;
  assign bus.RESULT_DATA  = w_in_wb ? bus.ALU_RESULT : r_res_data;
  assign bus.RESULT_DST   = w_in_wb ? r_dst : r_res_dst;

endmodule
